// File: rtl/frame_word_filler_if.sv
// Request, word and configuration bundle between the read sequencer, the
// word filler and the serialiser.
interface frame_word_filler_if #(
    parameter int CH_W   = 3,
    parameter int DATA_W = 8,
    parameter int PTR_W  = 9
);
    logic              get_word;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W+3:0] word_out;
    logic              word_valid;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic              cfg_sub;
    logic [2:0]        cfg_tag;
    logic [DATA_W-1:0] cfg_value;
    logic              err_ptr;

    modport master (
        output get_word, rd_ptr, cfg_we, cfg_ch, cfg_mode, cfg_sub, cfg_tag, cfg_value,
        input  word_out, word_valid, err_ptr
    );

    modport slave (
        input  get_word, rd_ptr, cfg_we, cfg_ch, cfg_mode, cfg_sub, cfg_tag, cfg_value,
        output word_out, word_valid, err_ptr
    );
endinterface

// File: rtl/frame_word_filler.sv
// Test-pattern word generator: one formatted word per read request, with each
// channel (rd_ptr mod NCH) acting as a constant, up/down counter or pointer echo.
module frame_word_filler #(
    parameter int NCH       = 8,
    parameter int CH_W      = 3,
    parameter int DATA_W    = 8,
    parameter int PTR_W     = 9,
    parameter int FRAME_LEN = 512,
    parameter int SUB_LEN   = 256,
    parameter int RST_STEP  = 11
) (
    input logic                clk,
    input logic                reset,
    frame_word_filler_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_UP    = 2'd1,
        MODE_DOWN  = 2'd2,
        MODE_ECHO  = 2'd3
    } mode_e;

    localparam logic [31:0]       FRAME_LEN_U = 32'(FRAME_LEN);
    localparam logic [31:0]       SUB_LEN_U   = 32'(SUB_LEN);
    localparam logic [DATA_W-1:0] ONE         = DATA_W'(1);

    logic [NCH-1:0][1:0]        ch_mode;
    logic [NCH-1:0]             ch_sub;
    logic [NCH-1:0][2:0]        ch_tag;
    logic [NCH-1:0][DATA_W-1:0] ch_value;

    logic [CH_W-1:0]   sel_ch;
    logic              in_range;
    logic              dup_ptr;
    logic              sub_first;
    logic              sel_counts;
    logic              step_en;
    logic [DATA_W-1:0] word_value;

    logic [DATA_W+3:0] word_q, word_d;
    logic              valid_q;
    logic              err_q, err_d;
    logic [PTR_W-1:0]  last_ptr_q, last_ptr_d;
    logic              last_valid_q, last_valid_d;

    always_comb begin
        sel_ch     = bus.rd_ptr[CH_W-1:0];
        in_range   = 32'(bus.rd_ptr) < FRAME_LEN_U;
        sub_first  = (32'(bus.rd_ptr) % SUB_LEN_U) == 32'(sel_ch);
        sel_counts = (ch_mode[sel_ch] == MODE_UP) || (ch_mode[sel_ch] == MODE_DOWN);
        // Repeats of the last serviced pointer re-emit the word without stepping.
        dup_ptr    = last_valid_q && (bus.rd_ptr == last_ptr_q);
        step_en    = bus.get_word && in_range && !dup_ptr && sel_counts
                     && (!ch_sub[sel_ch] || sub_first);
        word_value = (ch_mode[sel_ch] == MODE_ECHO) ? DATA_W'(bus.rd_ptr) : ch_value[sel_ch];

        word_d       = word_q;
        err_d        = err_q;
        last_ptr_d   = last_ptr_q;
        last_valid_d = last_valid_q;
        if (bus.get_word) begin
            if (in_range) begin
                word_d       = {1'b0, word_value, ch_tag[sel_ch]};
                last_ptr_d   = bus.rd_ptr;
                last_valid_d = 1'b1;
            end else begin
                word_d = {1'b0, {DATA_W{1'b0}}, 3'b010};
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            last_ptr_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            word_q       <= word_d;
            valid_q      <= bus.get_word;
            err_q        <= err_d;
            last_ptr_q   <= last_ptr_d;
            last_valid_q <= last_valid_d;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam logic [DATA_W-1:0] RST_VALUE = DATA_W'(gi * RST_STEP);
        localparam logic [2:0]        RST_TAG   = 3'(gi % 2);

        logic [1:0]        mode_q;
        logic              sub_q;
        logic [2:0]        tag_q;
        logic [DATA_W-1:0] value_q;
        logic              cfg_hit;
        logic              step_hit;

        assign cfg_hit  = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));
        assign step_hit = step_en && (sel_ch == CH_W'(gi));

        // A config write on the same edge as a step overrides the step.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mode_q  <= MODE_CONST;
                sub_q   <= 1'b0;
                tag_q   <= RST_TAG;
                value_q <= RST_VALUE;
            end else if (cfg_hit) begin
                mode_q  <= bus.cfg_mode;
                sub_q   <= bus.cfg_sub;
                tag_q   <= bus.cfg_tag;
                value_q <= bus.cfg_value;
            end else if (step_hit) begin
                value_q <= (mode_q == MODE_DOWN) ? value_q - ONE : value_q + ONE;
            end
        end

        assign ch_mode[gi]  = mode_q;
        assign ch_sub[gi]   = sub_q;
        assign ch_tag[gi]   = tag_q;
        assign ch_value[gi] = value_q;
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.err_ptr    = err_q;
endmodule

// File: tb/tb_frame_word_filler.sv
// Bench for frame_word_filler: directed vector table, multi-cycle sequences and
// a randomized run against a behavioural model of the word/step rules.
module tb_frame_word_filler;
    localparam int NCH       = 8;
    localparam int CH_W      = 3;
    localparam int DATA_W    = 8;
    localparam int PTR_W     = 10;
    localparam int FRAME_LEN = 512;
    localparam int SUB_LEN   = 256;
    localparam int RST_STEP  = 11;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    frame_word_filler_if #(.CH_W(CH_W), .DATA_W(DATA_W), .PTR_W(PTR_W)) bus_if ();

    frame_word_filler #(
        .NCH(NCH), .CH_W(CH_W), .DATA_W(DATA_W), .PTR_W(PTR_W),
        .FRAME_LEN(FRAME_LEN), .SUB_LEN(SUB_LEN), .RST_STEP(RST_STEP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        get;
        logic [9:0]  ptr;
        logic        we;
        logic [2:0]  ch;
        logic [1:0]  mode;
        logic        sub;
        logic [2:0]  tag;
        logic [7:0]  val;
        logic [11:0] exp_word;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    int m_mode[NCH];
    int m_sub[NCH];
    int m_tag[NCH];
    int m_val[NCH];
    int m_last;
    bit m_err;
    int m_word;
    bit m_valid;

    function automatic logic [11:0] w(input int v, input int t);
        logic [7:0] vv;
        logic [2:0] tt;
        vv = 8'(v);
        tt = 3'(t);
        return {1'b0, vv, tt};
    endfunction

    function automatic vec_t mk(input logic get, input int ptr, input logic we, input int ch,
                                input int mode, input logic sub, input int tag, input int val,
                                input logic [11:0] ew, input logic ev, input logic ee);
        vec_t r;
        r.get = get;      r.ptr = 10'(ptr);  r.we = we;   r.ch = 3'(ch);
        r.mode = 2'(mode); r.sub = sub;      r.tag = 3'(tag); r.val = 8'(val);
        r.exp_word = ew;  r.exp_valid = ev;  r.exp_err = ee;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic get, input int ptr, input logic we, input int ch,
                         input int mode, input logic sub, input int tag, input int val);
        bus_if.get_word  = get;
        bus_if.rd_ptr    = 10'(ptr);
        bus_if.cfg_we    = we;
        bus_if.cfg_ch    = 3'(ch);
        bus_if.cfg_mode  = 2'(mode);
        bus_if.cfg_sub   = sub;
        bus_if.cfg_tag   = 3'(tag);
        bus_if.cfg_value = 8'(val);
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_mode[k] = 0;
            m_sub[k]  = 0;
            m_tag[k]  = k % 2;
            m_val[k]  = (k * RST_STEP) % 256;
        end
        m_last  = -1;
        m_err   = 0;
        m_word  = 0;
        m_valid = 0;
    endfunction

    // Word uses pre-edge state; the config write is applied last so it wins over a step.
    function automatic void model_cycle(input bit get, input int ptr, input bit we, input int cch,
                                        input int cmode, input bit csub, input int ctag,
                                        input int cval);
        m_valid = get;
        if (get) begin
            if (ptr >= FRAME_LEN) begin
                m_word = 2;
                m_err  = 1;
            end else begin
                int ch;
                int v;
                ch = ptr % NCH;
                v  = (m_mode[ch] == 3) ? ptr % 256 : m_val[ch];
                m_word = v * 8 + m_tag[ch];
                if ((m_mode[ch] == 1 || m_mode[ch] == 2) && ptr != m_last
                    && (m_sub[ch] == 0 || ptr % SUB_LEN == ch))
                    m_val[ch] = (m_val[ch] + ((m_mode[ch] == 1) ? 1 : 255)) % 256;
                m_last = ptr;
            end
        end
        if (we) begin
            m_mode[cch] = cmode;
            m_sub[cch]  = csub;
            m_tag[cch]  = ctag;
            m_val[cch]  = cval;
        end
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus_if.get_word  = 1'b0;
        bus_if.rd_ptr    = '0;
        bus_if.cfg_we    = 1'b0;
        bus_if.cfg_ch    = '0;
        bus_if.cfg_mode  = '0;
        bus_if.cfg_sub   = 1'b0;
        bus_if.cfg_tag   = '0;
        bus_if.cfg_value = '0;

        // Directed vectors: get, ptr, we, ch, mode, sub, tag, val, exp word, valid, err
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, k, 0, 0, 0, 0, 0, 0, w(k * 11, k % 2), 1, 0));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   w(77, 1),  0, 0));
        vecs.push_back(mk(0, 0,   1, 5, 2, 0, 0, 2,   w(77, 1),  0, 0));
        vecs.push_back(mk(1, 5,   0, 0, 0, 0, 0, 0,   w(2, 0),   1, 0));
        vecs.push_back(mk(1, 13,  0, 0, 0, 0, 0, 0,   w(1, 0),   1, 0));
        vecs.push_back(mk(1, 21,  0, 0, 0, 0, 0, 0,   w(0, 0),   1, 0));
        vecs.push_back(mk(1, 29,  0, 0, 0, 0, 0, 0,   w(255, 0), 1, 0));
        vecs.push_back(mk(0, 0,   1, 5, 2, 0, 0, 10,  w(255, 0), 0, 0));
        vecs.push_back(mk(1, 5,   0, 0, 0, 0, 0, 0,   w(10, 0),  1, 0));
        vecs.push_back(mk(1, 5,   0, 0, 0, 0, 0, 0,   w(9, 0),   1, 0));
        vecs.push_back(mk(1, 5,   0, 0, 0, 0, 0, 0,   w(9, 0),   1, 0));
        vecs.push_back(mk(1, 13,  0, 0, 0, 0, 0, 0,   w(9, 0),   1, 0));
        vecs.push_back(mk(0, 0,   1, 3, 1, 0, 0, 40,  w(9, 0),   0, 0));
        vecs.push_back(mk(1, 3,   1, 3, 1, 0, 0, 100, w(40, 0),  1, 0));
        vecs.push_back(mk(1, 11,  0, 0, 0, 0, 0, 0,   w(100, 0), 1, 0));
        vecs.push_back(mk(0, 0,   1, 2, 3, 0, 0, 0,   w(100, 0), 0, 0));
        vecs.push_back(mk(1, 258, 0, 0, 0, 0, 0, 0,   w(2, 0),   1, 0));
        vecs.push_back(mk(1, 600, 0, 0, 0, 0, 0, 0,   12'h002,   1, 1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0,   12'h002,   0, 1));
        vecs.push_back(mk(1, 1,   0, 0, 0, 0, 0, 0,   w(11, 1),  1, 1));

        repeat (3) @(posedge clk);
        #1;
        check("rst_word", 32'(bus_if.word_out), 32'h0);
        check("rst_valid", 32'(bus_if.word_valid), 32'h0);
        check("rst_err", 32'(bus_if.err_ptr), 32'h0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].get, int'(vecs[i].ptr), vecs[i].we, int'(vecs[i].ch), int'(vecs[i].mode),
                  vecs[i].sub, int'(vecs[i].tag), int'(vecs[i].val));
            $display("vec %0d get=%0d ptr=%0d we=%0d word=%03h valid=%0d err=%0d", i,
                     vecs[i].get, vecs[i].ptr, vecs[i].we, bus_if.word_out, bus_if.word_valid,
                     bus_if.err_ptr);
            check($sformatf("vec%0d_word", i), 32'(bus_if.word_out), 32'(vecs[i].exp_word));
            check($sformatf("vec%0d_valid", i), 32'(bus_if.word_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_err", i), 32'(bus_if.err_ptr), 32'(vecs[i].exp_err));
        end

        // ch0 UP once per sub-frame from 254, two full frame sweeps.
        drive(0, 0, 1, 0, 1, 1, 0, 254);
        for (int pass = 0; pass < 2; pass++) begin
            for (int p = 0; p < FRAME_LEN; p++) begin
                drive(1, p, 0, 0, 0, 0, 0, 0);
                if (p % NCH == 0) begin
                    int s;
                    int ev;
                    s  = pass * 2 + p / SUB_LEN;
                    ev = (p % SUB_LEN == 0) ? (254 + s) % 256 : (255 + s) % 256;
                    $display("sweep pass=%0d ptr=%0d word=%03h", pass, p, bus_if.word_out);
                    check($sformatf("sweep%0d_p%0d", pass, p), 32'(bus_if.word_out), 32'(w(ev, 0)));
                end
            end
        end

        // Reset mid-stream: async clear, then the first request after reset steps.
        drive(1, 4, 0, 0, 0, 0, 0, 0);
        check("pre_rst_word", 32'(bus_if.word_out), 32'(w(44, 0)));
        reset = 1'b0;
        #1;
        $display("midreset word=%03h valid=%0d err=%0d", bus_if.word_out, bus_if.word_valid,
                 bus_if.err_ptr);
        check("midrst_word", 32'(bus_if.word_out), 32'h0);
        check("midrst_err", 32'(bus_if.err_ptr), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(0, 0, 1, 4, 1, 0, 0, 50);
        drive(1, 4, 0, 0, 0, 0, 0, 0);
        $display("postreset ptr=4 word=%03h", bus_if.word_out);
        check("postrst_first", 32'(bus_if.word_out), 32'(w(50, 0)));
        drive(1, 4, 0, 0, 0, 0, 0, 0);
        $display("postreset ptr=4 word=%03h", bus_if.word_out);
        check("postrst_dup", 32'(bus_if.word_out), 32'(w(51, 0)));
        drive(1, 12, 0, 0, 0, 0, 0, 0);
        $display("postreset ptr=12 word=%03h", bus_if.word_out);
        check("postrst_next", 32'(bus_if.word_out), 32'(w(51, 0)));

        // Randomized traffic against the model.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        model_reset();
        begin
            int prev_ptr;
            prev_ptr = 0;
            for (int i = 0; i < 1500; i++) begin
                bit get;
                bit we;
                bit csub;
                int ptr;
                int r;
                int cch;
                int cmode;
                int ctag;
                int cval;
                get = ($urandom_range(0, 3) != 0);
                r   = $urandom_range(0, 9);
                if (r < 3)       ptr = prev_ptr;
                else if (r < 5)  ptr = $urandom_range(0, 7) + 256 * $urandom_range(0, 1);
                else if (r == 9) ptr = $urandom_range(512, 1023);
                else             ptr = $urandom_range(0, 511);
                we    = ($urandom_range(0, 7) == 0);
                cch   = $urandom_range(0, 7);
                cmode = $urandom_range(0, 3);
                csub  = 1'($urandom_range(0, 1));
                ctag  = $urandom_range(0, 7);
                cval  = $urandom_range(0, 255);
                model_cycle(get, ptr, we, cch, cmode, csub, ctag, cval);
                drive(get, ptr, we, cch, cmode, csub, ctag, cval);
                if (get) prev_ptr = ptr;
                $display("rnd %0d get=%0d ptr=%0d we=%0d word=%03h valid=%0d err=%0d", i, get,
                         ptr, we, bus_if.word_out, bus_if.word_valid, bus_if.err_ptr);
                check($sformatf("rnd%0d_word", i), 32'(bus_if.word_out), 32'(m_word));
                check($sformatf("rnd%0d_valid", i), 32'(bus_if.word_valid), 32'(m_valid));
                check($sformatf("rnd%0d_err", i), 32'(bus_if.err_ptr), 32'(m_err));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_word_filler.md
Name: frame_word_filler

Overview:
- Parametrised test-pattern generator for the telemetry frame imitator. Produces one formatted data word per buffer read request.
- The read pointer selects a channel as rd_ptr mod NCH. Each channel is runtime-configurable as a constant, an up/down counter, or a pointer echo.
- Sits between the frame buffer read sequencer and the serialiser. Replaces the fixed 8-channel filler.

Parameters:
- NCH, 8, channel count; power of two, 2..32
- CH_W, 3, log2(NCH)
- DATA_W, 8, payload width per word
- PTR_W, 9, read pointer width
- FRAME_LEN, 512, valid pointer range 0..FRAME_LEN-1
- SUB_LEN, 256, sub-frame length; must divide FRAME_LEN and be a multiple of NCH
- RST_STEP, 11, reset constant step: channel k resets to (k*RST_STEP) mod 2^DATA_W

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- get_word  in  1  word request, sampled on the clk rising edge
- rd_ptr  in  PTR_W  buffer read pointer; valid with get_word
- word_out  out  DATA_W+4  {1'b0, value[DATA_W-1:0], tag[2:0]}
- word_valid  out  1  one-cycle pulse; word_out updated this cycle
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  CH_W  channel being configured
- cfg_mode  in  2  0=CONST, 1=UP, 2=DOWN, 3=PTR_ECHO
- cfg_sub  in  1  counter step policy: 0=every visit, 1=once per sub-frame
- cfg_tag  in  3  tag bits appended to this channel's word
- cfg_value  in  DATA_W  constant value, or counter seed
- err_ptr  out  1  sticky flag: a request arrived with rd_ptr >= FRAME_LEN

Behaviour:
- Reset (async, reset=0):
  - word_out=0, word_valid=0, err_ptr=0.
  - Channel k: mode=CONST, sub=0, tag={2'b00,k[0]}, value=(k*RST_STEP) mod 2^DATA_W.
  - last_ptr is invalidated.
- Latency: get_word at edge N → word_out and word_valid=1 after edge N. word_valid=0 on any cycle without a request. word_out holds its value between requests.
- Channel select: ch = rd_ptr[CH_W-1:0].
- Word contents by mode:
  - CONST → value.
  - UP/DOWN → current counter value, then the counter steps by +1/-1 (mod 2^DATA_W, wraps 255→0 and 0→255).
  - PTR_ECHO → rd_ptr[DATA_W-1:0]; the stored value is unchanged.
- Step rules:
  - The word always carries the pre-step value.
  - sub=0: step on every qualifying visit.
  - sub=1: step only when (rd_ptr mod SUB_LEN) == ch, i.e. the first visit in each sub-frame.
- Duplicate guard: a request with rd_ptr equal to the previous serviced pointer re-outputs the word but never steps a counter. Consecutive repeats of the same pointer step at most once.
- Out-of-range pointer (rd_ptr >= FRAME_LEN): word_out={1'b0, 0, 3'b010}, word_valid=1, err_ptr set. No counter steps, last_ptr unchanged. err_ptr clears only on reset.
- Config write (cfg_we=1): mode, sub, tag and value are loaded at the edge. The write takes effect for requests from the next edge onward.
- Simultaneous config write and request to the same channel:
  - The word uses the old configuration and old value.
  - The config write wins over the step; the counter takes cfg_value.
  - last_ptr is still updated.
- Reset mid-stream: all state returns to reset values immediately. The first request after reset always steps, if the channel mode allows it.
- Storage: per-channel registers, NCH x (2+1+3+DATA_W). No RAM inference needed.

Test Plan:
- Reset state: no config writes, request ptrs 0..7 → words {0,0,000}, {0,11,001}, {0,22,000}, ... {0,77,001}; err_ptr=0; word_valid pulses 1 cycle after each request.
- UP counter, per sub-frame:
  - Setup: cfg ch0 UP, sub=1, value=254, tag=000.
  - Sweep ptr 0..511 twice → ch0 words at ptr 0 read 254, 255, 0, 1 across the four sub-frame starts.
  - Other ch0 visits repeat the current value.
- DOWN counter, every visit:
  - Setup: cfg ch5 DOWN, sub=0, value=2.
  - Visits at ptr 5, 13, 21, 29 → values 2, 1, 0, 255.
- Duplicate guard: ch5 DOWN from 10; request ptr 5 on three consecutive cycles, then ptr 13 → 10, 9, 9, 9.
- Collision: ch3 UP at 40; same edge, request ptr 3 with cfg_we (ch3, UP, value=100) → word reads 40; next visit at ptr 11 reads 100.
- Out-of-range and PTR_ECHO:
  - PTR_W=10, FRAME_LEN=512: ptr 600 → word {0,0,010}, err_ptr=1, and err_ptr stays set.
  - ch2 in PTR_ECHO: ptr 258 → value 258 mod 256 = 2.
